// File: rtl/calc1_port_driver.sv
// rtl/calc1_port_driver.sv - calc1 request-port initiator with response timeout and golden-model check
module calc1_port_driver #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 5
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        host_valid,
  input  logic [3:0]  host_cmd,
  input  logic [31:0] host_op1,
  input  logic [31:0] host_op2,
  output logic        host_ready,
  output logic [3:0]  req_cmd_in,
  output logic [31:0] req_data_in,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  output logic        rsp_valid,
  output logic [1:0]  rsp_resp,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        rsp_mismatch,
  output logic        err_spurious
);

  typedef enum logic [2:0] {S_IDLE, S_SEND1, S_SEND2, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [31:0]       r_op2;
  logic [1:0]        r_exp_resp, w_exp_resp;
  logic [31:0]       r_exp_data, w_exp_data;
  logic [32:0]       w_sum;
  logic              w_accept;

  logic              r_host_ready, w_host_ready_nxt;
  logic [3:0]        r_req_cmd, w_req_cmd_nxt;
  logic [31:0]       r_req_data, w_req_data_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [1:0]        r_rsp_resp, w_rsp_resp_nxt;
  logic [31:0]       r_rsp_data, w_rsp_data_nxt;
  logic              r_rsp_timeout, w_rsp_timeout_nxt;
  logic              r_rsp_mismatch, w_rsp_mismatch_nxt;
  logic              r_err_spurious, w_err_spurious_nxt;

  // Expected result is computed from the host operands at accept time
  always_comb begin
    w_exp_resp = 2'd3;
    w_exp_data = '0;
    w_sum      = {1'b0, host_op1} + {1'b0, host_op2};
    case (host_cmd)
      4'd0: w_exp_resp = 2'd0;
      4'd1: begin
        if (w_sum[32]) w_exp_resp = 2'd2;
        else begin
          w_exp_resp = 2'd1;
          w_exp_data = w_sum[31:0];
        end
      end
      4'd2: begin
        if (host_op2 > host_op1) w_exp_resp = 2'd2;
        else begin
          w_exp_resp = 2'd1;
          w_exp_data = host_op1 - host_op2;
        end
      end
      4'd5: begin
        w_exp_resp = 2'd1;
        w_exp_data = host_op1 << host_op2[4:0];
      end
      4'd6: begin
        w_exp_resp = 2'd1;
        w_exp_data = host_op1 >> host_op2[4:0];
      end
      default: w_exp_resp = 2'd3;
    endcase
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_accept           = 1'b0;
    w_req_cmd_nxt      = '0;
    w_req_data_nxt     = '0;
    w_rsp_valid_nxt    = 1'b0;
    w_rsp_resp_nxt     = r_rsp_resp;
    w_rsp_data_nxt     = r_rsp_data;
    w_rsp_timeout_nxt  = r_rsp_timeout;
    w_rsp_mismatch_nxt = r_rsp_mismatch;
    case (r_state)
      S_IDLE: begin
        if (host_valid) begin
          w_accept = 1'b1;
          if (host_cmd == 4'd0) begin
            w_state_nxt        = S_DONE;
            w_rsp_valid_nxt    = 1'b1;
            w_rsp_resp_nxt     = 2'd0;
            w_rsp_data_nxt     = '0;
            w_rsp_timeout_nxt  = 1'b0;
            w_rsp_mismatch_nxt = 1'b0;
          end else begin
            w_state_nxt    = S_SEND1;
            w_req_cmd_nxt  = host_cmd;
            w_req_data_nxt = host_op1;
          end
        end
      end
      S_SEND1: begin
        w_state_nxt    = S_SEND2;
        w_req_data_nxt = r_op2;
      end
      S_SEND2: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end
      S_WAIT: begin
        // A response on the final timeout cycle takes priority over the timeout
        if (out_resp != 2'd0) begin
          w_state_nxt        = S_DONE;
          w_rsp_valid_nxt    = 1'b1;
          w_rsp_resp_nxt     = out_resp;
          w_rsp_data_nxt     = out_data;
          w_rsp_timeout_nxt  = 1'b0;
          w_rsp_mismatch_nxt = (out_resp != r_exp_resp) ||
                               ((out_resp == 2'd1) && (out_data != r_exp_data));
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt        = S_DONE;
          w_rsp_valid_nxt    = 1'b1;
          w_rsp_resp_nxt     = 2'd0;
          w_rsp_data_nxt     = '0;
          w_rsp_timeout_nxt  = 1'b1;
          w_rsp_mismatch_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_host_ready_nxt   = (w_state_nxt == S_IDLE);
    w_err_spurious_nxt = r_err_spurious || ((out_resp != 2'd0) && (r_state != S_WAIT));
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_op2          <= '0;
      r_exp_resp     <= '0;
      r_exp_data     <= '0;
      r_host_ready   <= 1'b1;
      r_req_cmd      <= '0;
      r_req_data     <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_resp     <= '0;
      r_rsp_data     <= '0;
      r_rsp_timeout  <= 1'b0;
      r_rsp_mismatch <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      if (w_accept) begin
        r_op2      <= host_op2;
        r_exp_resp <= w_exp_resp;
        r_exp_data <= w_exp_data;
      end
      r_host_ready   <= w_host_ready_nxt;
      r_req_cmd      <= w_req_cmd_nxt;
      r_req_data     <= w_req_data_nxt;
      r_rsp_valid    <= w_rsp_valid_nxt;
      r_rsp_resp     <= w_rsp_resp_nxt;
      r_rsp_data     <= w_rsp_data_nxt;
      r_rsp_timeout  <= w_rsp_timeout_nxt;
      r_rsp_mismatch <= w_rsp_mismatch_nxt;
      r_err_spurious <= w_err_spurious_nxt;
    end
  end

  assign host_ready   = r_host_ready;
  assign req_cmd_in   = r_req_cmd;
  assign req_data_in  = r_req_data;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_resp     = r_rsp_resp;
  assign rsp_data     = r_rsp_data;
  assign rsp_timeout  = r_rsp_timeout;
  assign rsp_mismatch = r_rsp_mismatch;
  assign err_spurious = r_err_spurious;

endmodule

// File: tb/tb_calc1_port_driver.sv
// tb/tb_calc1_port_driver.sv - self-checking bench for calc1_port_driver
module tb_calc1_port_driver;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_valid = 1'b0;
  logic [3:0]  host_cmd = '0;
  logic [31:0] host_op1 = '0;
  logic [31:0] host_op2 = '0;
  logic        host_ready;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  out_resp = '0;
  logic [31:0] out_data = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        rsp_mismatch;
  logic        err_spurious;

  int n_checks = 0;
  int n_fail   = 0;

  calc1_port_driver #(.TIMEOUT(15), .CNT_W(5)) dut (
    .c_clk(c_clk), .reset(reset), .host_valid(host_valid), .host_cmd(host_cmd),
    .host_op1(host_op1), .host_op2(host_op2), .host_ready(host_ready),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .out_resp(out_resp),
    .out_data(out_data), .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .rsp_mismatch(rsp_mismatch), .err_spurious(err_spurious)
  );

  always #5 c_clk = ~c_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Reference result from the arithmetic rules of each command
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [1:0] r, output logic [31:0] d);
    logic [63:0] wide;
    wide = {32'h0, a} + {32'h0, b};
    d = '0;
    case (c)
      4'd0: r = 2'd0;
      4'd1: if (wide > 64'hFFFF_FFFF) r = 2'd2; else begin r = 2'd1; d = wide[31:0]; end
      4'd2: if (b > a) r = 2'd2; else begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << (b % 32); end
      4'd6: begin r = 2'd1; d = a >> (b % 32); end
      default: r = 2'd3;
    endcase
  endfunction

  // One full transaction; responder injects (iresp, idata) on WAIT cycle 'delay' (0 = silent)
  task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input int delay, input logic [1:0] iresp, input logic [31:0] idata,
                        output int nvalid, output int lat, output logic [1:0] g_resp,
                        output logic [31:0] g_data, output logic g_to, output logic g_mm,
                        output logic [3:0] s1_cmd, output logic [31:0] s1_data,
                        output logic [3:0] s2_cmd, output logic [31:0] s2_data,
                        output logic wait_bus_nz, output logic busy_ready,
                        output logic [1:0] hold_resp);
    int k;
    nvalid = 0; lat = 0; g_resp = '0; g_data = '0; g_to = 1'b0; g_mm = 1'b0;
    s1_cmd = '0; s1_data = '0; s2_cmd = '0; s2_data = '0; wait_bus_nz = 1'b0; busy_ready = 1'b0;
    k = 0;
    @(negedge c_clk);
    while (!host_ready && k < 50) begin
      @(negedge c_clk);
      k++;
    end
    n_checks++;
    if (!host_ready) begin
      n_fail++;
      $display("FAIL host_ready_wait: host_ready=%0b required 1 within 50 cycles", host_ready);
    end
    host_valid = 1'b1; host_cmd = cmd; host_op1 = a; host_op2 = b;
    for (int c = 1; c <= 24; c++) begin
      @(negedge c_clk);
      if (c == 1) host_valid = 1'b0;
      out_resp = '0; out_data = '0;
      if (c == 1) begin s1_cmd = req_cmd_in; s1_data = req_data_in; busy_ready = host_ready; end
      if (c == 2) begin s2_cmd = req_cmd_in; s2_data = req_data_in; end
      if (c >= 3 && (req_cmd_in != 0 || req_data_in != 0)) wait_bus_nz = 1'b1;
      if (rsp_valid) begin
        if (nvalid == 0) begin
          lat = c; g_resp = rsp_resp; g_data = rsp_data; g_to = rsp_timeout; g_mm = rsp_mismatch;
        end
        nvalid++;
      end
      if (delay > 0 && c == 2 + delay) begin out_resp = iresp; out_data = idata; end
    end
    hold_resp = rsp_resp;
  endtask

  int          nv, lat;
  logic [1:0]  gr, hr;
  logic [31:0] gd;
  logic        gt, gm, wnz, brdy;
  logic [3:0]  s1c, s2c;
  logic [31:0] s1d, s2d;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge c_clk);
    @(negedge c_clk);
    reset = 1'b0;
    @(negedge c_clk);
    n_checks++;
    if (host_ready !== 1'b1 || req_cmd_in !== 4'd0 || req_data_in !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bus: ready=%0b cmd=%0h data=%0h required 1/0/0", host_ready, req_cmd_in, req_data_in);
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || err_spurious !== 1'b0 || rsp_resp !== 2'd0 ||
        rsp_timeout !== 1'b0 || rsp_mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: valid=%0b spur=%0b resp=%0d to=%0b mm=%0b required all 0",
               rsp_valid, err_spurious, rsp_resp, rsp_timeout, rsp_mismatch);
    end
  endtask

  task automatic test_add();
    run_op(4'd1, 32'h5, 32'h7, 1, 2'd1, 32'h0C, nv, lat, gr, gd, gt, gm, s1c, s1d, s2c, s2d, wnz, brdy, hr);
    n_checks++;
    if (nv !== 1 || lat !== 4) begin
      n_fail++; $display("FAIL add_pulse: count=%0d latency=%0d required 1/4", nv, lat);
    end
    n_checks++;
    if (gr !== 2'd1 || gd !== 32'h0C || gm !== 1'b0 || gt !== 1'b0) begin
      n_fail++; $display("FAIL add_result: resp=%0d data=%0h mm=%0b to=%0b required 1/c/0/0", gr, gd, gm, gt);
    end
    n_checks++;
    if (s1c !== 4'd1 || s1d !== 32'h5 || s2c !== 4'd0 || s2d !== 32'h7 || wnz !== 1'b0 || brdy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_bus: s1=%0h/%0h s2=%0h/%0h waitnz=%0b ready=%0b required 1/5 0/7 0 0",
               s1c, s1d, s2c, s2d, wnz, brdy);
    end
    n_checks++;
    if (hr !== 2'd1) begin
      n_fail++; $display("FAIL add_hold: rsp_resp=%0d required 1 after pulse", hr);
    end
  endtask

  task automatic test_overflow();
    run_op(4'd1, 32'hFFFF_FFFF, 32'h1, 2, 2'd2, 32'h0, nv, lat, gr, gd, gt, gm, s1c, s1d, s2c, s2d, wnz, brdy, hr);
    n_checks++;
    if (nv !== 1 || gr !== 2'd2 || gm !== 1'b0) begin
      n_fail++; $display("FAIL ovf_ok: count=%0d resp=%0d mm=%0b required 1/2/0", nv, gr, gm);
    end
    run_op(4'd1, 32'hFFFF_FFFF, 32'h1, 1, 2'd1, 32'h0, nv, lat, gr, gd, gt, gm, s1c, s1d, s2c, s2d, wnz, brdy, hr);
    n_checks++;
    if (nv !== 1 || gr !== 2'd1 || gm !== 1'b1) begin
      n_fail++; $display("FAIL ovf_bad: count=%0d resp=%0d mm=%0b required 1/1/1", nv, gr, gm);
    end
  endtask

  task automatic test_misc_ops();
    logic [3:0]  cmds [4] = '{4'd2, 4'd5, 4'd4, 4'd6};
    logic [31:0] op1s [4] = '{32'h3, 32'h1, 32'h9, 32'h8000_0000};
    logic [31:0] op2s [4] = '{32'h5, 32'h21, 32'h1, 32'h3F};
    logic [1:0]  rsps [4] = '{2'd2, 2'd1, 2'd3, 2'd1};
    logic [31:0] dats [4] = '{32'h0, 32'h2, 32'h0, 32'h1};
    logic [1:0]  mr;
    logic [31:0] md;
    for (int i = 0; i < 4; i++) begin
      model(cmds[i], op1s[i], op2s[i], mr, md);
      run_op(cmds[i], op1s[i], op2s[i], 1 + i, mr, md, nv, lat, gr, gd, gt, gm, s1c, s1d, s2c, s2d, wnz, brdy, hr);
      n_checks++;
      if (nv !== 1 || gr !== rsps[i] || gm !== 1'b0 || (rsps[i] == 2'd1 && gd !== dats[i])) begin
        n_fail++;
        $display("FAIL misc_op%0d: count=%0d resp=%0d data=%0h mm=%0b required 1/%0d/%0h/0",
                 i, nv, gr, gd, gm, rsps[i], dats[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] a, b, idata;
    logic [1:0]  mr, iresp;
    logic [31:0] md;
    logic        exp_mm;
    int          d;
    for (int i = 0; i < 24; i++) begin
      c = 4'($urandom_range(0, 15));
      if (i % 3 == 0) c = 4'd1 + 4'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      if (i % 4 == 1) a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      model(c, a, b, mr, md);
      iresp = mr; idata = md;
      if ($urandom_range(0, 3) == 0) begin iresp = 2'($urandom_range(1, 3)); idata = $urandom; end
      d = (c == 4'd0) ? 0 : $urandom_range(1, 6);
      exp_mm = (c != 4'd0) && ((iresp != mr) || (iresp == 2'd1 && idata != md));
      run_op(c, a, b, d, iresp, idata, nv, lat, gr, gd, gt, gm, s1c, s1d, s2c, s2d, wnz, brdy, hr);
      n_checks++;
      if (c == 4'd0) begin
        if (nv !== 1 || lat !== 1 || gr !== 2'd0 || gm !== 1'b0 || gt !== 1'b0 || s1c !== 4'd0 || s1d !== 32'd0) begin
          n_fail++;
          $display("FAIL rand%0d_noop: count=%0d lat=%0d resp=%0d mm=%0b to=%0b bus=%0h/%0h required 1/1/0/0/0/0/0",
                   i, nv, lat, gr, gm, gt, s1c, s1d);
        end
      end else if (nv !== 1 || lat !== 3 + d || gr !== iresp || gd !== idata || gm !== exp_mm || gt !== 1'b0 ||
                   s1c !== c || s1d !== a || s2d !== b || wnz !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d cmd=%0d: count=%0d lat=%0d resp=%0d data=%0h mm=%0b to=%0b required 1/%0d/%0d/%0h/%0b/0",
                 i, c, nv, lat, gr, gd, gm, gt, 3 + d, iresp, idata, exp_mm);
      end
    end
  endtask

  task automatic test_timeout();
    run_op(4'd2, 32'h10, 32'h1, 0, 2'd0, 32'h0, nv, lat, gr, gd, gt, gm, s1c, s1d, s2c, s2d, wnz, brdy, hr);
    n_checks++;
    if (nv !== 1 || lat !== 18 || gt !== 1'b1 || gr !== 2'd0 || gm !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: count=%0d lat=%0d to=%0b resp=%0d mm=%0b required 1/18/1/0/0", nv, lat, gt, gr, gm);
    end
    run_op(4'd2, 32'h10, 32'h1, 15, 2'd1, 32'hF, nv, lat, gr, gd, gt, gm, s1c, s1d, s2c, s2d, wnz, brdy, hr);
    n_checks++;
    if (nv !== 1 || lat !== 18 || gt !== 1'b0 || gr !== 2'd1 || gd !== 32'hF || gm !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_edge: count=%0d lat=%0d to=%0b resp=%0d data=%0h mm=%0b required 1/18/0/1/f/0",
               nv, lat, gt, gr, gd, gm);
    end
    n_checks++;
    if (err_spurious !== 1'b0) begin
      n_fail++; $display("FAIL no_spurious: err_spurious=%0b required 0", err_spurious);
    end
  endtask

  task automatic test_reset_wait();
    int cnt;
    @(negedge c_clk);
    host_valid = 1'b1; host_cmd = 4'd1; host_op1 = 32'h1; host_op2 = 32'h2;
    @(negedge c_clk);
    host_valid = 1'b0;
    repeat (3) @(negedge c_clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (host_ready !== 1'b1 || req_cmd_in !== 4'd0 || req_data_in !== 32'd0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wait: ready=%0b cmd=%0h data=%0h valid=%0b required 1/0/0/0",
               host_ready, req_cmd_in, req_data_in, rsp_valid);
    end
    @(negedge c_clk);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge c_clk);
      if (rsp_valid) cnt++;
    end
    n_checks++;
    if (cnt !== 0 || err_spurious !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_rsp: pulses=%0d spur=%0b required 0/0", cnt, err_spurious);
    end
    out_resp = 2'd1;
    @(negedge c_clk);
    out_resp = 2'd0;
    @(negedge c_clk);
    n_checks++;
    if (err_spurious !== 1'b1) begin
      n_fail++; $display("FAIL spurious_set: err_spurious=%0b required 1", err_spurious);
    end
    run_op(4'd5, 32'h3, 32'h4, 1, 2'd1, 32'h30, nv, lat, gr, gd, gt, gm, s1c, s1d, s2c, s2d, wnz, brdy, hr);
    n_checks++;
    if (err_spurious !== 1'b1 || nv !== 1 || gr !== 2'd1 || gm !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_sticky: spur=%0b count=%0d resp=%0d mm=%0b required 1/1/1/0", err_spurious, nv, gr, gm);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_misc_ops();
    test_random();
    test_timeout();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
